led_pattern_ctrl: RTL and testbench

Sequencer for the board's status LEDs: it drives the LED outputs through one of several selectable patterns, advancing one step per prescaled tick derived from `sys_clk`. Other logic chooses the pattern through a valid/ready mode port. It can also pre-empt the display with a one-shot "flash" request over a req/ack handshake. It replaces free-running counter-bit LED drivers at the top level and owns the `led` pins exclusively.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_prescaler.sv | 36 +++
 rtl/led_pattern_ctrl.sv | 135 +++++++++++++
 tb/tb_led_pattern_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the status LED sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLASH = 1'b1
  } state_e;

  // ceil(log2(n)), never less than 1 so a counter always has a bit
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << w) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running divide-by-DIV prescaler; tick is high while the count sits at DIV-1.
module led_prescaler
  import led_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: restart or wrap to zero, otherwise increment
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  // count register and registered terminal-count flag
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Status LED sequencer: selectable step patterns with a pre-emptive one-shot flash.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 27_000_000,
  parameter int unsigned TICK_HZ     = 4,
  parameter int unsigned LED_W       = 2,
  parameter int unsigned FLASH_TICKS = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [1:0]       mode_i,
  input  logic             mode_valid_i,
  output logic             mode_ready_o,
  input  logic             flash_req_i,
  output logic             flash_ack_o,
  output logic             tick_o,
  output logic [LED_W-1:0] led
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned FC_W = cnt_width(FLASH_TICKS);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_TICKS - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [LED_W-1:0]  pat_q, pat_d;
  logic [LED_W-1:0]  saved_q, saved_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [LED_W-1:0]  led_d;
  logic              tick_d;
  logic              ack_d;
  logic              ready_d;
  logic              mode_acc;
  logic              pre_tick;
  logic              step;

  function automatic logic [LED_W-1:0] pat_init(input mode_e m);
    case (m)
      MODE_BLINK: return '1;
      MODE_CHASE: return LED_W'(1);
      default:    return '0;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] pat_step(input mode_e m, input logic [LED_W-1:0] p);
    case (m)
      MODE_BLINK: return ~p;
      MODE_CHASE: return {p[LED_W-2:0], p[LED_W-1]};
      MODE_COUNT: return p + LED_W'(1);
      default:    return p;
    endcase
  endfunction

  // mode handshake; a mode change also restarts the step timebase
  assign mode_acc = mode_valid_i && mode_ready_o && (state_q == ST_RUN);

  led_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .restart (mode_acc),
    .tick    (pre_tick)
  );

  // a tick landing on a mode accept is dropped
  assign step = pre_tick && !mode_acc;

  // next-state, pattern bookkeeping and registered-output values
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    saved_d = saved_q;
    fcnt_d  = fcnt_q;
    ack_d   = 1'b0;
    tick_d  = step;
    case (state_q)
      ST_RUN: begin
        if (mode_acc) begin
          mode_d = mode_e'(mode_i);
          pat_d  = pat_init(mode_e'(mode_i));
        end else if (step) begin
          pat_d = pat_step(mode_q, pat_q);
        end
        if (flash_req_i) begin
          ack_d   = 1'b1;
          saved_d = pat_d;
          fcnt_d  = '0;
          state_d = ST_FLASH;
        end
      end
      ST_FLASH: begin
        if (step) begin
          if (fcnt_q == FC_LAST) begin
            state_d = ST_RUN;
            pat_d   = saved_q;
          end else begin
            fcnt_d = fcnt_q + FC_W'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    led_d   = (state_d == ST_FLASH) ? '1 : pat_d;
    ready_d = (state_d == ST_RUN);
  end

  // state, pattern storage and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q      <= ST_RUN;
      mode_q       <= MODE_OFF;
      pat_q        <= '0;
      saved_q      <= '0;
      fcnt_q       <= '0;
      led          <= '0;
      tick_o       <= 1'b0;
      flash_ack_o  <= 1'b0;
      mode_ready_o <= 1'b1;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pat_q        <= pat_d;
      saved_q      <= saved_d;
      fcnt_q       <= fcnt_d;
      led          <= led_d;
      tick_o       <= tick_d;
      flash_ack_o  <= ack_d;
      mode_ready_o <= ready_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed steps then random traffic against a step-count model.
module tb_led_pattern_ctrl;

  localparam int unsigned CLK_HZ      = 8;
  localparam int unsigned TICK_HZ     = 2;
  localparam int unsigned LW          = 2;
  localparam int unsigned FLASH_TICKS = 2;
  localparam int          DIV         = CLK_HZ / TICK_HZ;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic [1:0]    mode_i = '0;
  logic          mode_valid_i = 1'b0;
  logic          mode_ready_o;
  logic          flash_req_i = 1'b0;
  logic          flash_ack_o;
  logic          tick_o;
  logic [LW-1:0] led;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: pattern described by mode and number of steps taken
  int            m_mode = 0;
  int            m_k = 0;
  int            m_ph = 0;
  bit            m_flash = 1'b0;
  int            m_left = 0;
  logic [LW-1:0] e_led = '0;
  logic          e_tick = 1'b0;
  logic          e_ack = 1'b0;
  logic          e_ready = 1'b1;

  led_pattern_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .LED_W       (LW),
    .FLASH_TICKS (FLASH_TICKS)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .mode_i       (mode_i),
    .mode_valid_i (mode_valid_i),
    .mode_ready_o (mode_ready_o),
    .flash_req_i  (flash_req_i),
    .flash_ack_o  (flash_ack_o),
    .tick_o       (tick_o),
    .led          (led)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [LW-1:0] mpat(input int md, input int k);
    logic [LW-1:0] ones;
    ones = '1;
    case (md)
      1:       return (k % 2 == 0) ? ones : LW'(0);
      2:       return LW'(1 << (k % LW));
      3:       return LW'(k % (1 << LW));
      default: return LW'(0);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance the model by one clock edge given the inputs presented before it
  task automatic model_edge(input bit rst, input bit valid, input int md, input bit freq);
    bit acc;
    bit tk;
    if (!rst) begin
      m_mode = 0; m_k = 0; m_ph = 0; m_flash = 1'b0; m_left = 0;
      e_tick = 1'b0; e_ack = 1'b0;
    end else begin
      acc = !m_flash && valid;
      if (acc) m_ph = 0;
      else     m_ph++;
      tk = !acc && (m_ph % DIV == 0);
      e_tick = tk;
      e_ack  = 1'b0;
      if (!m_flash) begin
        if (acc) begin
          m_mode = md;
          m_k    = 0;
        end else if (tk) begin
          m_k++;
        end
        if (freq) begin
          e_ack   = 1'b1;
          m_flash = 1'b1;
          m_left  = FLASH_TICKS;
        end
      end else if (tk) begin
        m_left--;
        if (m_left == 0) m_flash = 1'b0;
      end
    end
    e_led   = m_flash ? '1 : mpat(m_mode, m_k);
    e_ready = !m_flash;
  endtask

  // one clock with the given inputs, then compare every output to the model
  task automatic cyc(input bit rst, input bit valid, input int md, input bit freq);
    sys_rst      = rst;
    mode_valid_i = valid;
    mode_i       = 2'(md);
    flash_req_i  = freq;
    model_edge(rst, valid, md, freq);
    @(posedge sys_clk);
    #1;
    chk("led",   led,                 e_led);
    chk("tick",  LW'(tick_o),         LW'(e_tick));
    chk("ack",   LW'(flash_ack_o),    LW'(e_ack));
    chk("ready", LW'(mode_ready_o),   LW'(e_ready));
  endtask

  initial begin
    int ticks;
    bit r;
    bit v;
    bit f;

    // reset held three cycles
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("rst_led", led, 2'b00);
    chk("rst_ready", LW'(mode_ready_o), 2'd1);

    // idle in OFF: ticks every DIV cycles, LEDs dark
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 0);
      ticks += int'(tick_o);
    end
    chk("idle_ticks", LW'(ticks), 2'd3);

    // CHASE: 01 immediately, then rotate per tick
    cyc(1, 1, 2, 0);
    chk("chase_init", led, 2'b01);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    chk("chase_step1", led, 2'b10);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);

    // COUNT: 00 -> 01 -> 10 -> 11 -> 00
    cyc(1, 1, 3, 0);
    chk("count_init", led, 2'b00);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
    chk("count_wrap", led, 2'b00);

    // BLINK, flash while showing 11, away from a tick
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      if (m_k % 2 == 0 && m_ph % DIV == 1) break;
      cyc(1, 0, 0, 0);
    end
    cyc(1, 0, 0, 1);
    chk("flash_ack", LW'(flash_ack_o), 2'd1);
    chk("flash_ready", LW'(mode_ready_o), 2'd0);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0);

    // mode accept and flash accept together
    cyc(1, 1, 2, 1);
    chk("both_led", led, 2'b11);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
    chk("both_restore", led, 2'b01);

    // reset during a flash
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_flash_led", led, 2'b00);
    chk("rst_flash_ready", LW'(mode_ready_o), 2'd1);
    cyc(1, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 63) != 0);
      v = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 9) == 0);
      cyc(r, v, int'($urandom_range(0, 3)), f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
